// File: rtl/axis_byte_to_word_packer_pkg.sv
// Shared constants, types and helpers for the byte-to-word packer.
// The keep-mask helper turns a fill index into a contiguous low-lane mask.
package axis_byte_to_word_packer_pkg;

  localparam int BYTE_W    = 8;
  localparam int DEF_RATIO = 4;
  localparam int MAX_RATIO = 8;

  typedef logic [$clog2(DEF_RATIO)-1:0] fill_idx_t;

  // idx=1 gives ...0011: lanes 0..idx inclusive
  function automatic logic [MAX_RATIO-1:0] keep_mask(input int idx);
    logic [MAX_RATIO-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_RATIO; i++) begin
      if (i <= idx) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/axis_byte_to_word_packer_if.sv
// Byte-in / word-out stream bundle for the packer.
// slave is the packer's view; master is the surrounding environment's view.
interface axis_byte_to_word_packer_if #(
  parameter int RATIO = 4
) ();
  import axis_byte_to_word_packer_pkg::*;

  logic [BYTE_W-1:0]       data_in;
  logic                    m_valid;
  logic                    m_ready;
  logic                    m_last;
  logic [BYTE_W*RATIO-1:0] s_data;
  logic [RATIO-1:0]        s_keep;
  logic                    s_valid;
  logic                    s_ready;
  logic                    s_last;

  modport master (
    output data_in, m_valid, m_last, s_ready,
    input  m_ready, s_data, s_keep, s_valid, s_last
  );

  modport slave (
    input  data_in, m_valid, m_last, s_ready,
    output m_ready, s_data, s_keep, s_valid, s_last
  );

endinterface

// File: rtl/axis_byte_to_word_packer_out_reg.sv
// Output holding register: captures a packed word and keeps it stable until
// the downstream side takes it; drain marks the accepting edge.
module axis_word_out_reg
  import axis_byte_to_word_packer_pkg::*;
#(
  parameter int RATIO = DEF_RATIO
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [BYTE_W*RATIO-1:0] word,
  input  logic [RATIO-1:0]        keep,
  input  logic                    last,
  input  logic                    s_ready,
  output logic                    s_valid,
  output logic [BYTE_W*RATIO-1:0] s_data,
  output logic [RATIO-1:0]        s_keep,
  output logic                    s_last,
  output logic                    drain
);

  logic                    s_valid_reg;
  logic [BYTE_W*RATIO-1:0] s_data_reg;
  logic [RATIO-1:0]        s_keep_reg;
  logic                    s_last_reg;

  assign drain = s_valid_reg && s_ready;

  // A load on a drain edge replaces the word with no bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_valid_reg <= 1'b0;
      s_data_reg  <= '0;
      s_keep_reg  <= '0;
      s_last_reg  <= 1'b0;
    end else if (load) begin
      s_valid_reg <= 1'b1;
      s_data_reg  <= word;
      s_keep_reg  <= keep;
      s_last_reg  <= last;
    end else if (drain) begin
      s_valid_reg <= 1'b0;
    end
  end

  assign s_valid = s_valid_reg;
  assign s_data  = s_data_reg;
  assign s_keep  = s_keep_reg;
  assign s_last  = s_last_reg;

endmodule

// File: rtl/axis_byte_to_word_packer.sv
// Packs an 8-bit stream into RATIO-byte little-endian words, flushing partial
// words on last, and counts packets fully handed downstream.
module axis_byte_to_word_packer
  import axis_byte_to_word_packer_pkg::*;
#(
  parameter int RATIO = DEF_RATIO,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  axis_byte_to_word_packer_if.slave bus,
  output logic [CNT_W-1:0]      pkt_cnt
);

  localparam int IDX_W  = $clog2(RATIO);
  localparam int WORD_W = BYTE_W * RATIO;

  typedef logic [IDX_W-1:0] idx_t;

  idx_t                               idx_reg;
  idx_t                               idx_next;
  logic [RATIO-1:0][BYTE_W-1:0]       acc_reg;
  logic [RATIO-1:0][BYTE_W-1:0]       acc_next;
  logic                               accept;
  logic                               complete;
  logic [RATIO-1:0]                   keep;
  logic [WORD_W-1:0]                  word;
  logic                               drain;
  logic [CNT_W-1:0]                   pkt_cnt_reg;

  // Input stalls whenever the output register holds an unaccepted word.
  assign bus.m_ready = rst && (!bus.s_valid || bus.s_ready);

  // State register: fill index plus lane accumulator.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_reg <= '0;
      acc_reg <= '0;
    end else begin
      idx_reg <= idx_next;
      acc_reg <= acc_next;
    end
  end

  // Next state: write lane idx, advance, or wrap to FILL0 on completion.
  always_comb begin
    idx_next = idx_reg;
    acc_next = acc_reg;
    if (complete) begin
      idx_next = '0;
      acc_next = '0;
    end else if (accept) begin
      idx_next = idx_reg + idx_t'(1);
      for (int i = 0; i < RATIO; i++) begin
        if (idx_reg == IDX_W'(i)) acc_next[i] = bus.data_in;
      end
    end
  end

  // Outputs of the fill FSM toward the holding register.
  always_comb begin
    accept   = bus.m_valid && bus.m_ready;
    complete = accept && ((idx_reg == IDX_W'(RATIO - 1)) || bus.m_last);
    keep     = RATIO'(keep_mask(int'(idx_reg)));
  end

  // The completing byte bypasses the accumulator into its lane.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign word[gi*BYTE_W +: BYTE_W] = !keep[gi]                 ? '0 :
                                       (idx_reg == IDX_W'(gi))   ? bus.data_in :
                                                                   acc_reg[gi];
  end

  axis_word_out_reg #(
    .RATIO (RATIO)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (complete),
    .word    (word),
    .keep    (keep),
    .last    (bus.m_last),
    .s_ready (bus.s_ready),
    .s_valid (bus.s_valid),
    .s_data  (bus.s_data),
    .s_keep  (bus.s_keep),
    .s_last  (bus.s_last),
    .drain   (drain)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_cnt_reg <= '0;
    end else if (drain && bus.s_last) begin
      pkt_cnt_reg <= pkt_cnt_reg + CNT_W'(1);
    end
  end

  assign pkt_cnt = pkt_cnt_reg;

endmodule
